// File: rtl/ir_left_shift1_for_pc.sv
// PC-offset generator: IR immediate shifted left by one (halfword aligned), combinational
// and registered with a sticky valid flag. Optional 16-bit sign-extended offset via IRLS_SIGNEXT16_EN.
module ir_left_shift1_for_pc #(
    parameter int IR_WIDTH = 13
) (
    input  logic                CLK,
    input  logic                Reset_n,
    input  logic [IR_WIDTH-1:0] IR,
    input  logic                Load,
    output logic [IR_WIDTH:0]   LeftShiftedOutput,
    output logic [IR_WIDTH:0]   OffsetReg,
    output logic                OffsetValid,
`ifdef IRLS_SIGNEXT16_EN
    output logic [15:0]         SignExtOffset,
`endif
    output logic                MsbLost
);

    logic [IR_WIDTH:0] shifted;
    logic [IR_WIDTH:0] offset_reg;
    logic              valid_reg;

    // Bit 0 is always zero; every IR bit moves up one position with no truncation.
    assign shifted[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < IR_WIDTH; gi++) begin : g_shift
            assign shifted[gi+1] = IR[gi];
        end
    endgenerate

    assign LeftShiftedOutput = shifted;
    assign MsbLost           = IR[IR_WIDTH-1];

`ifdef IRLS_SIGNEXT16_EN
    // Bits above the shifted result replicate its sign bit (the IR MSB).
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_sext
            if (gi <= IR_WIDTH) begin : g_low
                assign SignExtOffset[gi] = shifted[gi];
            end else begin : g_high
                assign SignExtOffset[gi] = IR[IR_WIDTH-1];
            end
        end
    endgenerate
`endif

    // Reset dominates Load, so a capture coinciding with reset is discarded.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            offset_reg <= '0;
            valid_reg  <= 1'b0;
        end else if (Load) begin
            offset_reg <= shifted;
            valid_reg  <= 1'b1;
        end
    end

    assign OffsetReg   = offset_reg;
    assign OffsetValid = valid_reg;

endmodule

// File: tb/tb_ir_left_shift1_for_pc.sv
// Self-checking bench for ir_left_shift1_for_pc: directed steps then randomized cycles
// against an arithmetic reference model.
module tb_ir_left_shift1_for_pc;

    logic        CLK;
    logic        Reset_n;
    logic [12:0] IR;
    logic        Load;
    logic [13:0] LeftShiftedOutput;
    logic [13:0] OffsetReg;
    logic        OffsetValid;
    logic        MsbLost;
`ifdef IRLS_SIGNEXT16_EN
    logic [15:0] SignExtOffset;
`endif

    ir_left_shift1_for_pc #(.IR_WIDTH(13)) dut (
        .CLK               (CLK),
        .Reset_n           (Reset_n),
        .IR                (IR),
        .Load              (Load),
        .LeftShiftedOutput (LeftShiftedOutput),
        .OffsetReg         (OffsetReg),
        .OffsetValid       (OffsetValid),
`ifdef IRLS_SIGNEXT16_EN
        .SignExtOffset     (SignExtOffset),
`endif
        .MsbLost           (MsbLost)
    );

    bit clk_run = 1'b0;
    initial begin
        CLK = 1'b0;
        forever begin
            #5;
            if (clk_run) CLK = ~CLK;
        end
    end

    int n_checks = 0;
    int n_fails  = 0;
    int exp_reg;
    int exp_valid;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
            $error("check %s differs", tag);
        end
    endtask

    // Reference: offset is IR times two; MSB of IR is the bit an IR-wide result would drop.
    task automatic check_comb(input string tag);
        int v;
        int s;
        v = int'(IR) * 2;
        check({tag, ".shift"}, 16'(LeftShiftedOutput), 16'(v));
        check({tag, ".msb"}, 16'(MsbLost), 16'(int'(IR) / 4096));
`ifdef IRLS_SIGNEXT16_EN
        s = (int'(IR) >= 4096) ? v - 16384 : v;
        check({tag, ".sext"}, SignExtOffset, 16'(s));
`else
        s = v;
`endif
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".reg"}, 16'(OffsetReg), 16'(exp_reg));
        check({tag, ".valid"}, 16'(OffsetValid), 16'(exp_valid));
    endtask

    initial begin
        Reset_n = 1'b1;
        Load    = 1'b0;
        IR      = 13'h1FFF;
        #100;
        check("static_1fff.shift", 16'(LeftShiftedOutput), 16'h3FFE);
        check("static_1fff.msb", 16'(MsbLost), 16'h0001);

        IR = 13'b1010101010101;
        #1;
        check("alt.shift", 16'(LeftShiftedOutput), 16'h2AAA);
        IR = 13'h0001;
        #1;
        check("one.shift", 16'(LeftShiftedOutput), 16'h0002);
        IR = 13'h0000;
        #1;
        check("zero.shift", 16'(LeftShiftedOutput), 16'h0000);
        check("zero.msb", 16'(MsbLost), 16'h0000);
`ifdef IRLS_SIGNEXT16_EN
        IR = 13'h1000;
        #1;
        check("sext_neg", SignExtOffset, 16'hE000);
        IR = 13'h0FFF;
        #1;
        check("sext_pos", SignExtOffset, 16'h1FFE);
`endif

        // Asynchronous reset with no clock running.
        Reset_n = 1'b0;
        #1;
        exp_reg = 0;
        exp_valid = 0;
        check_regs("async_rst_noclk");

        // Reset held with Load high while the clock runs.
        Load = 1'b1;
        IR   = 13'h0ABC;
        clk_run = 1'b1;
        repeat (3) begin
            @(posedge CLK); #1;
            check_regs("rst_load");
            check("rst_load.shift", 16'(LeftShiftedOutput), 16'h1578);
        end

        @(negedge CLK);
        Reset_n = 1'b1;
        @(posedge CLK); #1;
        exp_reg = 'h1578;
        exp_valid = 1;
        check_regs("first_load");

        @(negedge CLK);
        Load = 1'b0;
        IR   = 13'h1234;
        repeat (3) begin
            @(posedge CLK); #1;
            check_regs("hold");
            check("hold.shift", 16'(LeftShiftedOutput), 16'h2468);
        end
        #2;
        Reset_n = 1'b0;
        #1;
        exp_reg = 0;
        exp_valid = 0;
        check_regs("midcycle_rst");

        // Randomized cycles with occasional reset pulses.
        @(negedge CLK);
        Reset_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            IR      = 13'($urandom);
            Load    = 1'($urandom_range(0, 1));
            Reset_n = ($urandom_range(0, 11) != 0) || (i == 0);
            if (!Reset_n) begin
                exp_reg = 0;
                exp_valid = 0;
            end
            #1;
            check_comb("rand_neg");
            check_regs("rand_neg");
            @(posedge CLK);
            if (Reset_n && Load) begin
                exp_reg = int'(IR) * 2;
                exp_valid = 1;
            end
            #1;
            check_regs("rand_pos");
        end

        clk_run = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/ir_left_shift1_for_pc.md
Name: ir_left_shift1_for_pc

Overview:
PC-offset generator for the accumulator processor's branch/jump path. Takes the 13-bit immediate field of the instruction register and produces a 14-bit offset equal to that field shifted left by one bit (halfword-aligned address). Provides an immediate combinational result for the PC mux, plus a registered copy with a valid flag for pipelined PC-update logic.

Parameters:
IR_WIDTH, 13, width of the immediate field taken from IR; output width is IR_WIDTH+1.

Ports:
CLK  input  1  system clock, rising-edge active.
Reset_n  input  1  asynchronous, active-low reset; clears registered outputs only.
IR  input  IR_WIDTH  immediate field from the instruction register.
Load  input  1  capture enable for the registered offset.
LeftShiftedOutput  output  IR_WIDTH+1  combinational {IR, 1'b0}.
OffsetReg  output  IR_WIDTH+1  registered copy of LeftShiftedOutput.
OffsetValid  output  1  high when OffsetReg holds a captured value.
MsbLost  output  1  combinational; equals IR[IR_WIDTH-1], the bit that would be lost in an IR_WIDTH-wide result.

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- LeftShiftedOutput is purely combinational: LeftShiftedOutput[0] = 0; LeftShiftedOutput[i+1] = IR[i] for i = 0..IR_WIDTH-1.
- LeftShiftedOutput has no dependence on CLK, Reset_n or Load. It is valid within one delta of any IR change, including while Reset_n is low or CLK is static.
- No truncation. The full IR_WIDTH+1 result is produced; the MSB of IR appears at the output MSB.
- MsbLost = IR[IR_WIDTH-1], combinational.
- Reset_n low, asynchronously: OffsetReg = 0 and OffsetValid = 0. Both stay 0 while Reset_n is low, regardless of Load.
- Rising CLK edge with Reset_n high and Load = 1: OffsetReg <= {IR, 1'b0} and OffsetValid <= 1. Latency is 1 cycle.
- Rising CLK edge with Load = 0: OffsetReg and OffsetValid hold.
- Once set, OffsetValid stays 1 until the next reset. Back-to-back Loads overwrite OffsetReg every cycle.
- Reset asserted in the same cycle as Load: reset wins, and the capture is discarded.
- Reset release takes effect synchronously on the next edge evaluation. A Load on the first edge after release captures normally.
- No X propagation from Load when Reset_n is low.

Optional Feature:
Macro IRLS_SIGNEXT16_EN.
- Defined: adds output SignExtOffset, width 16. It is LeftShiftedOutput sign-extended from bit IR_WIDTH, i.e. bits 15..14 replicate IR[12] at default width. It is combinational and, like LeftShiftedOutput, independent of clock and reset.
- Undefined: the SignExtOffset port and its logic are absent. All other behaviour is identical.

Test Plan:
- No clock or reset activity; IR = 13'h1FFF, wait 100 ns -> LeftShiftedOutput = 14'b11111111111110, MsbLost = 1.
- IR changes to 13'b1010101010101 -> LeftShiftedOutput = 14'b10101010101010 after settle, MsbLost = 1.
- IR = 13'h0001, then 13'h0000 -> LeftShiftedOutput = 14'h0002, then 14'h0000, MsbLost = 0.
- Reset_n = 0 with Load = 1, IR = 13'h0ABC and clocks running -> OffsetReg = 0, OffsetValid = 0, while LeftShiftedOutput = 14'h1578. Release reset, one edge with Load = 1 -> OffsetReg = 14'h1578, OffsetValid = 1.
- Load = 0 and IR changes to 13'h1234 over 3 edges -> OffsetReg holds 14'h1578 while LeftShiftedOutput = 14'h2468. Assert Reset_n low mid-cycle -> OffsetReg = 0 immediately, without waiting for a clock edge.
- With IRLS_SIGNEXT16_EN: IR = 13'h1000 -> SignExtOffset = 16'hE000. IR = 13'h0FFF -> SignExtOffset = 16'h1FFE.
